// File: rtl/piso8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso8_pkg
//  Description : Shared types and constants for the piso8_tx serial
//                transmitter (state encoding, default width, counter width).
//  Revision    : 1.0  initial release
// ============================================================================
package piso8_pkg;

  // Transmitter states; ST_PARITY is only reachable when the parity
  // option (PISO8_TX_PARITY_EN) is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of the bit counter that indexes 0..width-1.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso8_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso8_tx_if
//  Description : Load handshake and serial link bundle for piso8_tx.
//                master = word source / link observer, slave = transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
interface piso8_tx_if
  import piso8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             PL;
  logic [WIDTH-1:0] di;
  logic             ready;
  logic             sout;
  logic             sframe;
  logic             done;

  modport master (output PL, di, input ready, sout, sframe, done);
  modport slave  (input PL, di, output ready, sout, sframe, done);
endinterface
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shreg
//  Description : WIDTH-bit shift register with synchronous parallel load and
//                shift enable. The head bit of a word goes straight onto the
//                line at load time, so the register is loaded already advanced
//                by one position and ser_out always presents the next bit to
//                transmit. Zeros are shifted in behind the data.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic [WIDTH-1:0] din,
  output logic                  ser_out
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] din_adv;
  logic [WIDTH-1:0] data_adv;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign din_adv  = {din[WIDTH-2:0], 1'b0};
      assign data_adv = {data[WIDTH-2:0], 1'b0};
      assign ser_out  = data[WIDTH-1];
    end else begin : g_lsb_first
      assign din_adv  = {1'b0, din[WIDTH-1:1]};
      assign data_adv = {1'b0, data[WIDTH-1:1]};
      assign ser_out  = data[0];
    end
  endgenerate

  // Load (advanced by one bit) has priority over shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= din_adv;
    end else if (shift) begin
      data <= data_adv;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso8_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso8_tx
//  Description : Parallel-in/serial-out transmitter. Accepts a word on PL
//                while ready, then sends it one bit per clock on sout with
//                sframe high, followed by a one-cycle done pulse.
//                Option macro PISO8_TX_PARITY_EN appends an even-parity bit.
//  Revision    : 1.0  initial release
// ============================================================================
module piso8_tx
  import piso8_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  piso8_tx_if.slave   bus
);

  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          sout_q, sout_nxt;
  logic          sframe_q, sframe_nxt;
  logic          done_q, done_nxt;
  logic          load, shift;
  logic          first_bit;
  logic          ser_next;

  assign first_bit = MSB_FIRST ? bus.di[WIDTH-1] : bus.di[0];

`ifdef PISO8_TX_PARITY_EN
  logic par_q, par_nxt;
`endif

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .din     (bus.di),
    .ser_out (ser_next)
  );

  // Next-state, counter and line-output decode.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    sout_nxt   = sout_q;
    sframe_nxt = sframe_q;
    done_nxt   = done_q;
    load       = 1'b0;
    shift      = 1'b0;
`ifdef PISO8_TX_PARITY_EN
    par_nxt    = par_q;
`endif
    case (state)
      ST_IDLE: begin
        if (bus.PL) begin
          load       = 1'b1;
          sout_nxt   = first_bit;
          sframe_nxt = 1'b1;
          count_nxt  = '0;
          state_nxt  = ST_SHIFT;
`ifdef PISO8_TX_PARITY_EN
          // Parity latched from the accepted word, not from live di.
          par_nxt    = ^bus.di;
`endif
        end
      end
      ST_SHIFT: begin
        if (count == LAST) begin
`ifdef PISO8_TX_PARITY_EN
          sout_nxt   = par_q;
          state_nxt  = ST_PARITY;
`else
          sout_nxt   = 1'b0;
          sframe_nxt = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = ST_DONE;
`endif
        end else begin
          shift     = 1'b1;
          count_nxt = count + 1'b1;
          sout_nxt  = ser_next;
        end
      end
`ifdef PISO8_TX_PARITY_EN
      ST_PARITY: begin
        sout_nxt   = 1'b0;
        sframe_nxt = 1'b0;
        done_nxt   = 1'b1;
        state_nxt  = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        sout_nxt   = 1'b0;
        sframe_nxt = 1'b0;
        done_nxt   = 1'b0;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO8_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      sout_q   <= sout_nxt;
      sframe_q <= sframe_nxt;
      done_q   <= done_nxt;
`ifdef PISO8_TX_PARITY_EN
      par_q    <= par_nxt;
`endif
    end
  end

  assign bus.ready  = (state == ST_IDLE);
  assign bus.sout   = sout_q;
  assign bus.sframe = sframe_q;
  assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso8_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso8_tx
//  Description : Self-checking bench for piso8_tx; drives an MSB-first and an
//                LSB-first instance with the same words and compares the
//                serial streams against queued expected bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso8_tx;

`ifdef PISO8_TX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pl;
  logic [7:0] di;
  int         vectors     = 0;
  int         miscompares = 0;
  logic       qm[$];
  logic       ql[$];

  piso8_tx_if #(.WIDTH(8)) bm ();
  piso8_tx_if #(.WIDTH(8)) bl ();

  assign bm.PL = pl;
  assign bm.di = di;
  assign bl.PL = pl;
  assign bl.di = di;

  piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
  piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Control outputs of both instances.
  task automatic chk_ctl(input string tag, input logic rdy, input logic sf, input logic dn);
    chk({tag, "_m_ready"}, bm.ready, rdy);
    chk({tag, "_m_sframe"}, bm.sframe, sf);
    chk({tag, "_m_done"}, bm.done, dn);
    chk({tag, "_l_ready"}, bl.ready, rdy);
    chk({tag, "_l_sframe"}, bl.sframe, sf);
    chk({tag, "_l_done"}, bl.done, dn);
  endtask

  task automatic chk_sout0(input string tag);
    chk({tag, "_m_sout"}, bm.sout, 1'b0);
    chk({tag, "_l_sout"}, bl.sout, 1'b0);
  endtask

  // Scoreboard: one expected bit per framed cycle for each instance.
  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) qm.push_back(w[i]);
    for (int i = 0; i < 8; i++)  ql.push_back(w[i]);
`ifdef PISO8_TX_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endtask

  task automatic pop_chk(input string tag);
    logic e;
    if (qm.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s_m_q: observed empty queue, expected a bit", tag);
    end else begin
      e = qm.pop_front();
      chk({tag, "_m_sout"}, bm.sout, e);
    end
    if (ql.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s_l_q: observed empty queue, expected a bit", tag);
    end else begin
      e = ql.pop_front();
      chk({tag, "_l_sout"}, bl.sout, e);
    end
  endtask

  // Send one word; if inj >= 0, pulse PL with 8'h55 during framed cycle inj.
  task automatic send(input logic [7:0] w, input int inj);
    string t;
    @(negedge clk);
    pl = 1'b1; di = w;
    push_word(w);
    @(negedge clk);
    pl = 1'b0; di = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      t = $sformatf("w%02h_b%0d", w, i);
      chk_ctl(t, 1'b0, 1'b1, 1'b0);
      pop_chk(t);
      if (i == inj) begin
        pl = 1'b1; di = 8'h55;
      end else begin
        pl = 1'b0; di = 8'h00;
      end
      @(negedge clk);
    end
    pl = 1'b0;
    t = $sformatf("w%02h_done", w);
    chk_ctl(t, 1'b0, 1'b0, 1'b1);
    chk_sout0(t);
    @(negedge clk);
    t = $sformatf("w%02h_rdy", w);
    chk_ctl(t, 1'b1, 1'b0, 1'b0);
    chk_sout0(t);
  endtask

  initial begin
    rst = 1'b1; pl = 1'b0; di = 8'h00;
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1'b1, 1'b0, 1'b0);
    chk_sout0("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0);
      chk_sout0($sformatf("idle%0d", i));
    end

    send(8'hAF, -1);
    send(8'h01, -1);
    send(8'h80, -1);
    // PL pulsed with 8'h55 mid-frame must not disturb the AF frame.
    send(8'hAF, 3);

    // Reset after the 4th bit aborts the frame with no done pulse.
    @(negedge clk);
    pl = 1'b1; di = 8'hAF;
    push_word(8'hAF);
    @(negedge clk);
    pl = 1'b0; di = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk_ctl($sformatf("abort_b%0d", i), 1'b0, 1'b1, 1'b0);
      pop_chk($sformatf("abort_b%0d", i));
      if (i < 3) @(negedge clk);
    end
    rst = 1'b1;
    qm.delete();
    ql.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("abort_rst", 1'b1, 1'b0, 1'b0);
    chk_sout0("abort_rst");
    @(negedge clk);
    chk_ctl("abort_after", 1'b1, 1'b0, 1'b0);
    chk_sout0("abort_after");

    send(8'hC3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso8_tx.md
# piso8_tx

Parallel-in/serial-out transmitter that is the opposite end of the 8-bit parallel-load register path. It accepts one byte on a load handshake and shifts it out one bit per clock, with a frame strobe and an end-of-word pulse. It sits downstream of the parallel register bank and drives a single-wire serial link to a matching serial-in receiver.

## Interface
- WIDTH, 8, data word width; legal values ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- PL  in  1  load request; accepted only on a posedge where ready=1.
- di  in  WIDTH  parallel data; sampled on the accepting edge.
- ready  out  1  high in IDLE only; transmitter can accept a word.
- sout  out  1  serial data (registered).
- sframe  out  1  high on every cycle sout carries a valid data or parity bit.
- done  out  1  one-cycle pulse after the last bit of a word.

## Operation
- States: IDLE, SHIFT, PARITY (only with PARITY_EN), DONE.
- IDLE: ready=1, sframe=0, sout=0. If PL=1 at the edge:
  - load the shift register from di;
  - drive the first bit onto sout; sframe<=1, ready<=0, bit count<=0;
  - go to SHIFT.
- PL=0 in IDLE: hold.
- SHIFT: each edge advances one bit.
  - After WIDTH bits have been presented, the next edge goes to PARITY if enabled.
  - Otherwise sframe<=0, sout<=0, done<=1, go to DONE.
- PARITY: sout carries the even-parity bit (XOR of all WIDTH data bits) with sframe=1. The next edge goes to DONE as above.
- DONE: done=1 for exactly one cycle. Next edge: done<=0, ready<=1, go to IDLE.
- PL outside IDLE is ignored, and di changes outside the accepting edge have no effect. No queuing: a request during a frame is lost unless still asserted in IDLE.
- Bit counter width: $clog2(WIDTH) bits. No wrap beyond WIDTH-1.
- The parity bit is computed from the loaded word, not from live di.

## Timing
- Reset values: ready=1, sout=0, sframe=0, done=0, state=IDLE, shift register=0, count=0. All take effect on the first edge with rst=1.
- Reset mid-frame aborts immediately: the next cycle shows the reset values and no done pulse.
- rst has priority over PL on the same edge.
- Accept at edge k:
  - data bits on cycles k..k+WIDTH-1 (after edges k..k+WIDTH-1);
  - parity on cycle k+WIDTH (if enabled);
  - done high one cycle later;
  - ready high the cycle after done.
- Throughput: one word per WIDTH+2 cycles, or WIDTH+3 with parity. Back-to-back PL held high yields a one-cycle sframe gap (DONE) plus one IDLE cycle between words.

## Configuration
- PISO8_TX_PARITY_EN defined: PARITY state present; one even-parity bit is appended with sframe high; frame length WIDTH+1.
- Undefined: PARITY state, parity logic and its counter decode are absent; frame length WIDTH.

## Structure
- Shared package piso8_pkg:
  - state enum (IDLE, SHIFT, PARITY, DONE);
  - default WIDTH constant;
  - count-width function/constant.
- One sub-module, piso_shreg: WIDTH-bit shift register with synchronous parallel load, shift enable, direction set by MSB_FIRST, and a serial output.
- The FSM, counter and parity logic stay in piso8_tx.

## Test plan
- Reset, then idle 3 cycles -> ready=1, sout=0, sframe=0, done=0 throughout.
- di=8'hAF, PL=1 one cycle, MSB_FIRST=1, no parity -> sout 1,0,1,0,1,1,1,1 over 8 sframe cycles, then done pulse, then ready=1 one cycle later.
- Same with MSB_FIRST=0 -> sout 1,1,1,1,0,1,0,1.
- PISO8_TX_PARITY_EN, di=8'hAF -> 8 data bits followed by parity bit 0. di=8'h01 -> parity bit 1. sframe high for 9 cycles.
- PL pulsed again with di=8'h55 during the SHIFT of 8'hAF -> ignored; the AF frame is unchanged and ready stays 0 until after done.
- rst asserted after the 4th bit of 8'hAF -> next cycle sout=0, sframe=0, ready=1, no done pulse. A fresh PL then transmits the full new word.
